// File: rtl/port_tx_serializer.sv
// Output-port serializer: CPU byte writes queue in a small FIFO and shift out as 8N1 frames.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module port_tx_serializer #(
  parameter int DEPTH = 4,
  parameter int DIV   = 16,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       clr_ovf,
  output logic       tx,
  output logic [7:0] status,
  output logic       busy
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  state_t            state, next_state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
`ifdef PARITY_EN
  logic              parity_bit;
`endif
  logic              fifo_empty, fifo_full, pop, push, bit_done;
  logic [2:0]        count_lsb;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign bit_done   = (baud_cnt == BAUD_LAST);
  assign busy       = (state != IDLE);

  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign pop  = (state == IDLE) && !fifo_empty;
  assign push = wr_en && (!fifo_full || pop);

  always_comb begin
    count_lsb = '0;
    for (int i = 0; i < 3 && i < CNT_W; i++) count_lsb[i] = count[i];
  end

  assign status = {1'b0, count_lsb, overflow, busy, fifo_full, fifo_empty};

  always_comb begin
    next_state = state;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) next_state = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_done) next_state = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
`ifdef PARITY_EN
        if (bit_done && bit_idx == 3'd7) next_state = PARITY;
`else
        if (bit_done && bit_idx == 3'd7) next_state = STOP;
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        tx = parity_bit;
        if (bit_done) next_state = STOP;
      end
`endif
      STOP: begin
        if (bit_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Baud counter restarts at every bit boundary and idles at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (state == IDLE || bit_done) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        bit_idx   <= '0;
`ifdef PARITY_EN
        parity_bit <= ^mem[rd_ptr];
`endif
      end else if (state == DATA && bit_done) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_idx   <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A rejected write outranks a simultaneous clear.
      if (wr_en && !push) overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_port_tx_serializer.sv
// Directed bench for port_tx_serializer (DEPTH=4, DIV=4); honours PARITY_EN when defined.
module tb_port_tx_serializer;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int CNT_W = 3;
`ifdef PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx;
  logic [7:0] status;
  logic       busy;

  int check_count = 0;
  int pass_count  = 0;
  logic [7:0] rx_q[$];
  logic [10:0] mon_bits;
  bit          mon_abort;

  port_tx_serializer #(.DEPTH(DEPTH), .DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .clr_ovf(clr_ovf), .tx(tx), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    wr_data = data;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic logic [10:0] frameBits(input logic [7:0] d);
`ifdef PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, 1'b1, d, 1'b0};
`endif
  endfunction

  // Called just after the write edge into an empty, idle FIFO; checks every tx sample.
  task automatic exactFrame(input logic [7:0] d);
    logic [10:0] bits;
    bits = frameBits(d);
    checkOutput("tx_before_start", tx, 1);
    checkOutput("status_after_write", status, 8'h10);
    tick();
    checkOutput("status_frame_start", status, 8'h05);
    for (int b = 0; b < FRAME_BITS; b++)
      for (int s = 0; s < DIV; s++) begin
        checkOutput("frame_tx", tx, bits[b]);
        tick();
      end
    checkOutput("busy_after_frame", busy, 0);
    checkOutput("status_after_frame", status, 8'h01);
  endtask

  task automatic waitFrames(input int n, input int budget);
    int waited = 0;
    while (rx_q.size() < n && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput("rx_frame_count", rx_q.size(), n);
  endtask

  task automatic waitIdle(input int budget);
    int waited = 0;
    while (busy && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput("idle_reached", busy, 0);
  endtask

  // Background receiver: mid-bit sampling, abandons a frame if reset drops.
  initial begin
    forever begin
      tick();
      if (reset && tx == 1'b0) begin
        mon_abort = 1'b0;
        mon_bits  = '0;
        for (int k = 0; k < FRAME_BITS * DIV; k++) begin
          if (!reset) mon_abort = 1'b1;
          if (k % DIV == DIV / 2) mon_bits[k / DIV] = tx;
          if (k < FRAME_BITS * DIV - 1) tick();
        end
        if (!mon_abort && reset) begin
          checkOutput("rx_stop_bit", mon_bits[FRAME_BITS-1], 1);
`ifdef PARITY_EN
          checkOutput("rx_parity_bit", mon_bits[9], ^mon_bits[8:1]);
`endif
          rx_q.push_back(mon_bits[8:1]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] burst [5];
    logic [7:0] burst_status [5];
    logic [7:0] fill [5];
    int low_cnt;
    burst        = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    burst_status = '{8'h10, 8'h14, 8'h24, 8'h34, 8'h46};
    fill         = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};

    #2;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_status", status, 8'h01);
    #10 reset = 1'b1;
    tick();
    checkOutput("post_reset_status", status, 8'h01);

    // Single frames, exact bit timing
    applyStimulus(8'hA5);
    exactFrame(8'hA5);
    applyStimulus(8'h07);
    exactFrame(8'h07);
    applyStimulus(8'h03);
    exactFrame(8'h03);
    checkOutput("rx_count_single", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      checkOutput("rx_a5", rx_q[0], 8'hA5);
      checkOutput("rx_07", rx_q[1], 8'h07);
      checkOutput("rx_03", rx_q[2], 8'h03);
    end
    rx_q.delete();

    // Five back-to-back writes while idle: all accepted
    for (int i = 0; i < 5; i++) begin
      applyStimulus(burst[i]);
      checkOutput("burst_status", status, burst_status[i]);
    end
    waitFrames(5, 400);
    if (rx_q.size() == 5)
      for (int i = 0; i < 5; i++) checkOutput("burst_rx_order", rx_q[i], burst[i]);
    waitIdle(100);
    checkOutput("burst_final_status", status, 8'h01);
    rx_q.delete();

    // Overflow while busy and full, then clear; set beats clear
    for (int i = 0; i < 5; i++) applyStimulus(fill[i]);
    checkOutput("full_status", status, 8'h46);
    applyStimulus(8'h77);
    checkOutput("overflow_set", status, 8'h4E);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checkOutput("overflow_cleared", status, 8'h46);
    wr_data = 8'h99;
    wr_en   = 1'b1;
    clr_ovf = 1'b1;
    tick();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    checkOutput("set_beats_clear", status, 8'h4E);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checkOutput("overflow_cleared2", status, 8'h46);

    // Full FIFO with a pop on the write edge: write accepted
    waitIdle(200);
    checkOutput("full_idle_status", status, 8'h42);
    applyStimulus(8'h88);
    checkOutput("full_push_pop_status", status, 8'h46);
    waitFrames(6, 600);
    if (rx_q.size() == 6) begin
      for (int i = 0; i < 5; i++) checkOutput("fill_rx_order", rx_q[i], fill[i]);
      checkOutput("push_pop_rx", rx_q[5], 8'h88);
    end
    waitIdle(100);
    checkOutput("fill_final_status", status, 8'h01);
    rx_q.delete();

    // Asynchronous reset during data bit 3
    applyStimulus(8'h00);
    applyStimulus(8'h5A);
    repeat (4 * DIV + 1) tick();
    checkOutput("mid_frame_tx", tx, 0);
    checkOutput("mid_frame_status", status, 8'h14);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_tx", tx, 1);
    checkOutput("async_reset_status", status, 8'h01);
    checkOutput("async_reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 15 * DIV; i++) begin
      tick();
      if (tx == 1'b0) low_cnt++;
    end
    checkOutput("no_residual_frame", low_cnt, 0);
    checkOutput("no_residual_rx", rx_q.size(), 0);
    checkOutput("after_reset_status", status, 8'h01);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/port_tx_serializer.md
Name: port_tx_serializer

Overview:
- CPU-side output-port consumer that buffers bytes the processor writes to an output register, then shifts them out on an asynchronous serial line.
- Write side: CPU output register value plus its one-cycle write strobe.
- Read side: a status byte wired to one of the processor's selectable input ports, so firmware can poll it with an input instruction.
- Single clock domain.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..8
DIV, 16, clocks per serial bit; >= 2
CNT_W, 3, width of occupancy count; must hold 0..DEPTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
wr_data  input  8  byte from CPU output register
wr_en  input  1  one-cycle write strobe (we5 & port decode)
clr_ovf  input  1  one-cycle pulse; clears sticky overflow flag
tx  output  1  serial line, idle high
status  output  8  to CPU input port
busy  output  1  serializer not IDLE

Behaviour:
- Reset (reset=0, async) forces the following immediately:
  - tx=1, busy=0, state IDLE.
  - FIFO empty, pointers and count 0, overflow 0.
  - status=8'h01.
- Reset mid-frame abandons the frame; queued bytes are lost.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; count 0..DEPTH.
- Write is accepted on a clk edge when wr_en=1 and (count<DEPTH or a pop occurs the same edge).
- Write with count=DEPTH and no simultaneous pop: byte dropped, overflow<=1 (sticky).
- clr_ovf=1 clears overflow. If clr_ovf and a rejected write coincide, overflow ends 1 (set wins).
- Serializer FSM states: IDLE, START, DATA, STOP (plus PARITY when PARITY_EN is defined).
- Baud counter runs 0..DIV-1. Each non-IDLE state bit lasts exactly DIV clocks.
- IDLE: tx=1. If count>0 at an edge: pop head into shift register, go START. The pop is visible in status the same edge.
- START: tx=0 for DIV clocks, then DATA with bit index 0.
- DATA: tx=shift[0], LSB first. Shift right every DIV clocks. After bit 7, go STOP (or PARITY).
- STOP: tx=1 for DIV clocks, then IDLE. Back-to-back frames: IDLE lasts exactly one clock between a STOP and the next START.
- Latency: write at edge N into empty FIFO while IDLE:
  - edge N+1: pop, state START.
  - tx falls after edge N+1.
  - frame ends 10*DIV clocks after edge N+1 (11*DIV with parity).
- status bits:
  - [0]=empty (count==0)
  - [1]=full (count==DEPTH)
  - [2]=busy
  - [3]=overflow
  - [6:4]=count (CNT_W LSBs, zero-extended)
  - [7]=0
- All status bits are registered values; no combinational path from wr_en to status.
- wr_en held high for multiple cycles writes once per cycle (no edge detection).

Optional Feature:
PARITY_EN
- Defined: PARITY state inserted between DATA and STOP. tx = XOR of the 8 data bits (even parity), lasting DIV clocks. Frame is 11 bits.
- Undefined: no PARITY state, 10-bit frame. Status and timing are otherwise identical.

Test Plan:
- DIV=4, reset released, write 8'hA5 once:
  - tx=1 before edge N+1.
  - then 0 for 4 clk.
  - then 1,0,1,0,0,1,0,1 each for 4 clk.
  - then 1 for 4 clk.
  - busy=0 and status=8'h01 afterwards.
- Write 5 bytes on consecutive cycles while IDLE, DEPTH=4:
  - first byte popped at 2nd edge, so all 5 accepted.
  - status count peaks at 4, full=1, overflow=0.
  - five frames transmitted in order.
- With serializer busy and FIFO full (status=8'h46), write 8'h77: dropped, status=8'h4E. Then pulse clr_ovf: status returns to 8'h46.
- FIFO full and pop occurring the same edge as wr_en: write accepted, count stays 4, overflow stays 0.
- Assert reset=0 during DATA bit 3, no clock edge: tx=1, status=8'h01 immediately. After release, no residual frame.
- PARITY_EN defined, DIV=4, write 8'h07: parity bit 1 after bit 7. Frame lasts 44 clk. Then write 8'h03: parity bit 0.
